// File: rtl/hazard_idex_stage.sv
// Load-use / branch hazard detector plus the ID/EX pipeline register with a stall counter.
// Latency: ID/EX outputs are registered (1 cycle); PC_Write/IFID_Write are combinational.
// Backpressure: a hazard inserts a bubble and drops PC_Write/IFID_Write; Flush overrides any stall.
module hazard_idex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IFID_Valid,
  input  logic [REG_W-1:0]  IFID_RS,
  input  logic [REG_W-1:0]  IFID_RT,
  input  logic              IFID_UsesRT,
  input  logic [REG_W-1:0]  IFID_WriteReg,
  input  logic              IFID_RegWrite,
  input  logic              IFID_MemRead,
  input  logic              IFID_MemWrite,
  input  logic              IFID_Branch,
  input  logic [DATA_W-1:0] RegData1,
  input  logic [DATA_W-1:0] RegData2,
  input  logic [DATA_W-1:0] Imm,
  input  logic              Flush,
  output logic [REG_W-1:0]  IDEX_RS,
  output logic [REG_W-1:0]  IDEX_RT,
  output logic [REG_W-1:0]  IDEX_WriteReg,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic [DATA_W-1:0] IDEX_Data1,
  output logic [DATA_W-1:0] IDEX_Data2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t state;

  logic dep_on_ex;   // instruction in ID reads the register EX is producing
  logic load_use;
  logic br_alu;
  logic br_load;
  logic stall;       // bubble that freezes the front end and is counted
  logic load_instr;  // ID/EX captures the decoded instruction

  // Register 0 is hardwired, so it can never create a dependency.
  assign dep_on_ex = IFID_Valid && (IDEX_WriteReg != '0) &&
                     ((IDEX_WriteReg == IFID_RS) ||
                      (IFID_UsesRT && (IDEX_WriteReg == IFID_RT)));

  assign load_use = IDEX_MemRead && dep_on_ex;
  assign br_alu   = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && dep_on_ex;
  assign br_load  = IFID_Branch && IDEX_MemRead && dep_on_ex;

  // Flush squashes the ID instruction anyway, so it never stalls the front end.
  assign stall      = !Flush && ((state == BR_WAIT) || load_use || br_alu || br_load);
  assign load_instr = !Flush && !stall && IFID_Valid;
  assign PC_Write   = !stall;
  assign IFID_Write = !stall;

  // Branch-on-load needs a second bubble, tracked by BR_WAIT; Flush abandons it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else if (Flush || (state == BR_WAIT)) begin
      state <= RUN;
    end else if (br_load) begin
      state <= BR_WAIT;
    end else begin
      state <= RUN;
    end
  end

  // ID/EX register: take the decoded instruction or load an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IDEX_RS       <= '0;
      IDEX_RT       <= '0;
      IDEX_WriteReg <= '0;
      IDEX_RegWrite <= 1'b0;
      IDEX_MemRead  <= 1'b0;
      IDEX_MemWrite <= 1'b0;
      IDEX_Data1    <= '0;
      IDEX_Data2    <= '0;
      IDEX_Imm      <= '0;
    end else if (load_instr) begin
      IDEX_RS       <= IFID_RS;
      IDEX_RT       <= IFID_RT;
      IDEX_WriteReg <= IFID_WriteReg;
      IDEX_RegWrite <= IFID_RegWrite;
      IDEX_MemRead  <= IFID_MemRead;
      IDEX_MemWrite <= IFID_MemWrite;
      IDEX_Data1    <= RegData1;
      IDEX_Data2    <= RegData2;
      IDEX_Imm      <= Imm;
    end else begin
      IDEX_RS       <= '0;
      IDEX_RT       <= '0;
      IDEX_WriteReg <= '0;
      IDEX_RegWrite <= 1'b0;
      IDEX_MemRead  <= 1'b0;
      IDEX_MemWrite <= 1'b0;
      IDEX_Data1    <= '0;
      IDEX_Data2    <= '0;
      IDEX_Imm      <= '0;
    end
  end

  // Count hazard bubbles only; saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= '0;
    end else if (stall && (StallCount != '1)) begin
      StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_idex_stage.sv
// Bench for hazard_idex_stage: directed hazard scenarios plus random traffic vs. a behavioural model.
// A narrow stall counter is used so saturation is reached in a few thousand cycles.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_hazard_idex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              IFID_Valid = 1'b0;
  logic [REG_W-1:0]  IFID_RS = '0;
  logic [REG_W-1:0]  IFID_RT = '0;
  logic              IFID_UsesRT = 1'b0;
  logic [REG_W-1:0]  IFID_WriteReg = '0;
  logic              IFID_RegWrite = 1'b0;
  logic              IFID_MemRead = 1'b0;
  logic              IFID_MemWrite = 1'b0;
  logic              IFID_Branch = 1'b0;
  logic [DATA_W-1:0] RegData1 = '0;
  logic [DATA_W-1:0] RegData2 = '0;
  logic [DATA_W-1:0] Imm = '0;
  logic              Flush = 1'b0;
  logic [REG_W-1:0]  IDEX_RS;
  logic [REG_W-1:0]  IDEX_RT;
  logic [REG_W-1:0]  IDEX_WriteReg;
  logic              IDEX_RegWrite;
  logic              IDEX_MemRead;
  logic              IDEX_MemWrite;
  logic [DATA_W-1:0] IDEX_Data1;
  logic [DATA_W-1:0] IDEX_Data2;
  logic [DATA_W-1:0] IDEX_Imm;
  logic              PC_Write;
  logic              IFID_Write;
  logic [CNT_W-1:0]  StallCount;

  int tests = 0;
  int fails = 0;

  hazard_idex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .IFID_Valid(IFID_Valid), .IFID_RS(IFID_RS), .IFID_RT(IFID_RT),
    .IFID_UsesRT(IFID_UsesRT), .IFID_WriteReg(IFID_WriteReg),
    .IFID_RegWrite(IFID_RegWrite), .IFID_MemRead(IFID_MemRead),
    .IFID_MemWrite(IFID_MemWrite), .IFID_Branch(IFID_Branch),
    .RegData1(RegData1), .RegData2(RegData2), .Imm(Imm), .Flush(Flush),
    .IDEX_RS(IDEX_RS), .IDEX_RT(IDEX_RT), .IDEX_WriteReg(IDEX_WriteReg),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_Data1(IDEX_Data1),
    .IDEX_Data2(IDEX_Data2), .IDEX_Imm(IDEX_Imm),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The ID/EX contents as an instruction record, a count of extra bubbles
  // still owed by a branch-on-load, and an integer stall tally.
  int m_rs, m_rt, m_wr;
  bit m_rw, m_mr, m_mw;
  logic [DATA_W-1:0] m_d1, m_d2, m_imm;
  int m_owed;
  int m_cnt;

  function automatic bit reads_reg(int r);
    if (!IFID_Valid || r == 0) return 1'b0;
    if (r == int'(IFID_RS)) return 1'b1;
    return IFID_UsesRT && (r == int'(IFID_RT));
  endfunction

  function automatic bit model_stall();
    bit lu, ba, bl;
    if (Flush) return 1'b0;
    if (m_owed > 0) return 1'b1;
    lu = m_mr && reads_reg(m_wr);
    ba = IFID_Branch && m_rw && !m_mr && reads_reg(m_wr);
    bl = IFID_Branch && m_mr && reads_reg(m_wr);
    return lu || ba || bl;
  endfunction

  function automatic bit model_br_load();
    return !Flush && (m_owed == 0) && IFID_Branch && m_mr && reads_reg(m_wr);
  endfunction

  task automatic model_bubble();
    m_rs = 0; m_rt = 0; m_wr = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_d1 = '0; m_d2 = '0; m_imm = '0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_bubble();
      m_owed = 0;
      m_cnt = 0;
    end else begin
      bit st, bl;
      st = model_stall();
      bl = model_br_load();
      if (Flush) begin
        model_bubble();
        m_owed = 0;
      end else if (st) begin
        model_bubble();
        m_owed = bl ? 1 : ((m_owed > 0) ? m_owed - 1 : 0);
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end else if (!IFID_Valid) begin
        model_bubble();
      end else begin
        m_rs = int'(IFID_RS); m_rt = int'(IFID_RT); m_wr = int'(IFID_WriteReg);
        m_rw = IFID_RegWrite; m_mr = IFID_MemRead; m_mw = IFID_MemWrite;
        m_d1 = RegData1; m_d2 = RegData2; m_imm = Imm;
      end
    end
  end

  // Compare every falling edge.
  always @(negedge clk) begin
    bit st;
    st = model_stall();
    chk("PC_Write", 64'(PC_Write), 64'(!st));
    chk("IFID_Write", 64'(IFID_Write), 64'(!st));
    chk("IDEX_RS", 64'(IDEX_RS), 64'(m_rs));
    chk("IDEX_RT", 64'(IDEX_RT), 64'(m_rt));
    chk("IDEX_WriteReg", 64'(IDEX_WriteReg), 64'(m_wr));
    chk("IDEX_ctrl", {61'd0, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite},
        {61'd0, m_rw, m_mr, m_mw});
    chk("IDEX_Data1", 64'(IDEX_Data1), 64'(m_d1));
    chk("IDEX_Data2", 64'(IDEX_Data2), 64'(m_d2));
    chk("IDEX_Imm", 64'(IDEX_Imm), 64'(m_imm));
    chk("StallCount", 64'(StallCount), 64'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit ut,
                       input int wr, input bit rw, input bit mr, input bit mw,
                       input bit br, input bit fl);
    IFID_Valid = v; IFID_RS = REG_W'(rs); IFID_RT = REG_W'(rt); IFID_UsesRT = ut;
    IFID_WriteReg = REG_W'(wr); IFID_RegWrite = rw; IFID_MemRead = mr;
    IFID_MemWrite = mw; IFID_Branch = br; Flush = fl;
    RegData1 = $urandom; RegData2 = $urandom; Imm = $urandom;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    // reset state
    #3;
    chk("reset PC_Write", 64'(PC_Write), 64'd1);
    chk("reset IFID_Write", 64'(IFID_Write), 64'd1);
    chk("reset IDEX_RegWrite", 64'(IDEX_RegWrite), 64'd0);
    chk("reset StallCount", 64'(StallCount), 64'd0);
    do_reset();

    // load-use: lw $8 then add using $8
    drive(1, 1, 2, 0, 8, 1, 1, 0, 0, 0);
    step();
    drive(1, 8, 2, 1, 10, 1, 0, 0, 0, 0);
    #2 chk("lu PC_Write", 64'(PC_Write), 64'd0);
    chk("lu IFID_Write", 64'(IFID_Write), 64'd0);
    step();
    chk("lu bubble RegWrite", 64'(IDEX_RegWrite), 64'd0);
    chk("lu StallCount", 64'(StallCount), 64'd1);
    chk("lu PC resumes", 64'(PC_Write), 64'd1);
    step();
    chk("lu add RS", 64'(IDEX_RS), 64'd8);
    chk("lu add WriteReg", 64'(IDEX_WriteReg), 64'd10);

    // branch after ALU: add $3 then beq on rt=$3
    do_reset();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 3, 1, 0, 0, 0, 0, 1, 0);
    #2 chk("ba PC_Write", 64'(PC_Write), 64'd0);
    step();
    chk("ba one bubble", 64'(PC_Write), 64'd1);
    chk("ba StallCount", 64'(StallCount), 64'd1);
    step();
    chk("ba beq RT", 64'(IDEX_RT), 64'd3);

    // branch after load: two bubbles
    do_reset();
    drive(1, 1, 2, 0, 5, 1, 1, 0, 0, 0);
    step();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("bl PC_Write 1st", 64'(PC_Write), 64'd0);
    step();
    chk("bl PC_Write 2nd", 64'(PC_Write), 64'd0);
    chk("bl StallCount 1", 64'(StallCount), 64'd1);
    step();
    chk("bl PC resumes", 64'(PC_Write), 64'd1);
    chk("bl StallCount 2", 64'(StallCount), 64'd2);
    step();
    chk("bl beq RS", 64'(IDEX_RS), 64'd5);

    // register zero and unused rt never stall
    do_reset();
    drive(1, 1, 2, 0, 0, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 2, 1, 4, 1, 1, 0, 0, 0);
    #2 chk("r0 no stall", 64'(PC_Write), 64'd1);
    drive(1, 1, 2, 0, 9, 1, 1, 0, 0, 0);
    step();
    drive(1, 1, 9, 0, 4, 1, 0, 0, 0, 0);
    #2 chk("rt unused no stall", 64'(PC_Write), 64'd1);

    // flush during BR_WAIT
    do_reset();
    drive(1, 1, 2, 0, 5, 1, 1, 0, 0, 0);
    step();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 chk("flush PC_Write", 64'(PC_Write), 64'd1);
    step();
    chk("flush StallCount", 64'(StallCount), 64'd1);
    chk("flush bubble RS", 64'(IDEX_RS), 64'd0);
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("flush back in RUN", 64'(PC_Write), 64'd1);

    // reset in the middle of BR_WAIT
    do_reset();
    drive(1, 1, 2, 0, 5, 1, 1, 0, 0, 0);
    step();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    #1 reset_n = 1'b0;
    #1 chk("rst mid PC_Write", 64'(PC_Write), 64'd1);
    chk("rst mid StallCount", 64'(StallCount), 64'd0);
    chk("rst mid MemRead", 64'(IDEX_MemRead), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("rst no stall after", 64'(PC_Write), 64'd1);

    // random traffic with a small register set to provoke hazards
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      step();
    end

    // saturation: repeated lw $5 that branches on $5 (3 cycles per 2 stalls)
    do_reset();
    drive(1, 5, 0, 0, 5, 1, 1, 0, 1, 0);
    for (int i = 0; i < (CNT_MAX * 3) / 2 + 20; i++) step();
    chk("sat StallCount", 64'(StallCount), 64'(CNT_MAX));
    for (int i = 0; i < 6; i++) step();
    chk("sat holds", 64'(StallCount), 64'(CNT_MAX));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
